// File: rtl/io_map_pkg.sv
// Address map and register-select decode shared by the MMIO bridge and its users.
package io_map_pkg;

    localparam logic [31:0] IO_BASE   = 32'hFFFF_FC00;

    localparam logic [7:0]  OFF_SW    = 8'h60;
    localparam logic [7:0]  OFF_TEST  = 8'h70;
    localparam logic [7:0]  OFF_BTNA  = 8'h74;
    localparam logic [7:0]  OFF_BTNB  = 8'h78;
    localparam logic [7:0]  OFF_SEG   = 8'h80;
    localparam logic [7:0]  OFF_LED   = 8'h90;
    localparam logic [7:0]  OFF_BLINK = 8'hA0;

    typedef enum logic [2:0] {
        IO_NONE,
        IO_SW,
        IO_TEST,
        IO_BTNA,
        IO_BTNB,
        IO_SEG,
        IO_LED,
        IO_BLINK
    } io_reg_e;

    function automatic io_reg_e io_decode(input logic [7:0] off);
        io_reg_e sel;
        sel = IO_NONE;
        case (off)
            OFF_SW:    sel = IO_SW;
            OFF_TEST:  sel = IO_TEST;
            OFF_BTNA:  sel = IO_BTNA;
            OFF_BTNB:  sel = IO_BTNB;
            OFF_SEG:   sel = IO_SEG;
            OFF_LED:   sel = IO_LED;
            OFF_BLINK: sel = IO_BLINK;
            default:   sel = IO_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_mmio_bridge_if.sv
// CPU-side load/store bus between the datapath and the MMIO bridge.
interface io_mmio_bridge_if;

    logic        IORead;
    logic        IOWrite;
    logic [31:0] ALU_result;
    logic [31:0] Read_data_2;
    logic [31:0] MemReadData;
    logic [31:0] MemorIO_Result;

    modport master (
        output IORead,
        output IOWrite,
        output ALU_result,
        output Read_data_2,
        output MemReadData,
        input  MemorIO_Result
    );

    modport slave (
        input  IORead,
        input  IOWrite,
        input  ALU_result,
        input  Read_data_2,
        input  MemReadData,
        output MemorIO_Result
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a button level plus a one-cycle rising-edge pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= level;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/io_mmio_bridge.sv
// Memory-mapped I/O bridge: write-back mux, display registers and sticky button flags.
module io_mmio_bridge #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int unsigned SEG_W   = 24,
    parameter int unsigned LED_W   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    io_mmio_bridge_if.slave      bus,
    input  logic [7:0]           IO_input,
    input  logic [2:0]           TEST_input,
    input  logic                 enterA,
    input  logic                 enterB,
    output logic [SEG_W-1:0]     IO_seg_out,
    output logic [LED_W-1:0]     IO_led_out,
    output logic                 IO_blink_out
);

    import io_map_pkg::*;

    logic [7:0]       off;
    io_reg_e          sel;
    logic [SEG_W-1:0] seg_q;
    logic [LED_W-1:0] led_q;
    logic             blink_q;
    logic             flag_a_q;
    logic             flag_b_q;
    logic             rise_a;
    logic             rise_b;
    logic             clr_a;
    logic             clr_b;
    logic [31:0]      io_rdata;
    logic             unused_bits;

    // control32 has already qualified the upper address bits; only the low byte selects a register
    assign off = bus.ALU_result[7:0] - IO_BASE[7:0];
    assign sel = io_decode(off);
    assign unused_bits = ^{bus.ALU_result[31:8], bus.Read_data_2};

    btn_edge_sync u_btn_a (
        .clk   (clk),
        .reset (reset),
        .level (enterA),
        .rise  (rise_a)
    );

    btn_edge_sync u_btn_b (
        .clk   (clk),
        .reset (reset),
        .level (enterB),
        .rise  (rise_b)
    );

    assign clr_a = bus.IOWrite && (sel == IO_BTNA);
    assign clr_b = bus.IOWrite && (sel == IO_BTNB);

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q    <= '0;
            led_q    <= '0;
            blink_q  <= 1'b0;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            if (bus.IOWrite) begin
                case (sel)
                    IO_SEG:   seg_q   <= bus.Read_data_2[SEG_W-1:0];
                    IO_LED:   led_q   <= bus.Read_data_2[LED_W-1:0];
                    IO_BLINK: blink_q <= bus.Read_data_2[0];
                    default:  ;
                endcase
            end
            // a fresh edge beats a clear landing in the same cycle
            flag_a_q <= rise_a | (flag_a_q & ~clr_a);
            flag_b_q <= rise_b | (flag_b_q & ~clr_b);
        end
    end

    always_comb begin
        io_rdata = '0;
        case (sel)
            IO_SW:    io_rdata = 32'(IO_input);
            IO_TEST:  io_rdata = 32'(TEST_input);
            IO_BTNA:  io_rdata = 32'(flag_a_q);
            IO_BTNB:  io_rdata = 32'(flag_b_q);
            IO_SEG:   io_rdata = 32'(seg_q);
            IO_LED:   io_rdata = 32'(led_q);
            IO_BLINK: io_rdata = 32'(blink_q);
            default:  io_rdata = '0;
        endcase
    end

    assign bus.MemorIO_Result = bus.IORead ? io_rdata : bus.MemReadData;

    assign IO_seg_out   = seg_q;
    assign IO_led_out   = led_q;
    assign IO_blink_out = blink_q;

endmodule

// File: tb/tb_io_mmio_bridge.sv
// Directed self-checking bench for io_mmio_bridge.
module tb_io_mmio_bridge;

    logic        clk;
    logic        reset;
    logic [7:0]  IO_input;
    logic [2:0]  TEST_input;
    logic        enterA;
    logic        enterB;
    logic [23:0] IO_seg_out;
    logic [23:0] IO_led_out;
    logic        IO_blink_out;

    int unsigned n_checks;
    int unsigned n_errors;

    io_mmio_bridge_if bus ();

    io_mmio_bridge #(
        .IO_BASE (32'hFFFF_FC00),
        .SEG_W   (24),
        .LED_W   (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .IO_input     (IO_input),
        .TEST_input   (TEST_input),
        .enterA       (enterA),
        .enterB       (enterB),
        .IO_seg_out   (IO_seg_out),
        .IO_led_out   (IO_led_out),
        .IO_blink_out (IO_blink_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.IORead      = 1'b0;
        bus.IOWrite     = 1'b1;
        bus.ALU_result  = addr;
        bus.Read_data_2 = data;
        step();
        bus.IOWrite     = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr);
        bus.IOWrite    = 1'b0;
        bus.IORead     = 1'b1;
        bus.ALU_result = addr;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        IO_input = '0;
        TEST_input = '0;
        enterA = 1'b0;
        enterB = 1'b0;
        bus.IORead = 1'b0;
        bus.IOWrite = 1'b1;
        bus.ALU_result = 32'hFFFF_FC80;
        bus.Read_data_2 = 32'hFFFF_FFFF;
        bus.MemReadData = 32'h0;

        // reset wins over a concurrent store
        step(3);
        reset = 1'b0;
        bus.IOWrite = 1'b0;
        #1;
        check("rst_seg", 32'(IO_seg_out), 32'h0);
        check("rst_led", 32'(IO_led_out), 32'h0);
        check("rst_blink", 32'(IO_blink_out), 32'h0);
        load(32'hFFFF_FC74);
        check("rst_flagA", bus.MemorIO_Result, 32'h0);

        // register stores: value appears only after the edge
        bus.IOWrite = 1'b1;
        bus.ALU_result = 32'hFFFF_FC80;
        bus.Read_data_2 = 32'hAB12_3456;
        bus.IORead = 1'b0;
        #1;
        check("seg_before_edge", 32'(IO_seg_out), 32'h0);
        step();
        bus.IOWrite = 1'b0;
        store(32'hFFFF_FC90, 32'h00FF_00FF);
        check("seg_out", 32'(IO_seg_out), 32'h0012_3456);
        check("led_out", 32'(IO_led_out), 32'h00FF_00FF);
        load(32'hFFFF_FC80);
        check("seg_read", bus.MemorIO_Result, 32'h0012_3456);
        load(32'hFFFF_FC90);
        check("led_read", bus.MemorIO_Result, 32'h00FF_00FF);
        store(32'hFFFF_FCA0, 32'h0000_0003);
        check("blink_out", 32'(IO_blink_out), 32'h1);
        load(32'hFFFF_FCA0);
        check("blink_read", bus.MemorIO_Result, 32'h1);

        // switches and RAM pass-through
        IO_input = 8'hA5;
        TEST_input = 3'b101;
        bus.MemReadData = 32'hDEAD_BEEF;
        load(32'hFFFF_FC60);
        check("sw_read", bus.MemorIO_Result, 32'h0000_00A5);
        load(32'hFFFF_FC70);
        check("test_read", bus.MemorIO_Result, 32'h0000_0005);
        load(32'hFFFF_FCF0);
        check("unmapped_read", bus.MemorIO_Result, 32'h0);
        bus.IORead = 1'b0;
        bus.ALU_result = 32'hFFFF_FC60;
        #1;
        check("ram_pass_io_addr", bus.MemorIO_Result, 32'hDEAD_BEEF);
        bus.ALU_result = 32'h1234_5678;
        #1;
        check("ram_pass_mem_addr", bus.MemorIO_Result, 32'hDEAD_BEEF);
        bus.IORead = 1'b1;
        bus.IOWrite = 1'b1;
        bus.ALU_result = 32'hFFFF_FC60;
        #1;
        check("read_priority", bus.MemorIO_Result, 32'h0000_00A5);
        bus.IOWrite = 1'b0;

        // button A: three edges of latency, then sticky
        enterA = 1'b1;
        load(32'hFFFF_FC74);
        step(2);
        check("flagA_lat2", bus.MemorIO_Result, 32'h0);
        step();
        check("flagA_lat3", bus.MemorIO_Result, 32'h1);
        step(4);
        check("flagA_sticky", bus.MemorIO_Result, 32'h1);
        store(32'hFFFF_FC74, 32'h0);
        load(32'hFFFF_FC74);
        check("flagA_clear", bus.MemorIO_Result, 32'h0);
        step(3);
        check("flagA_held_no_reset", bus.MemorIO_Result, 32'h0);
        enterA = 1'b0;
        step(4);
        enterA = 1'b1;
        step(3);
        check("flagA_repress", bus.MemorIO_Result, 32'h1);
        enterA = 1'b0;

        // button B: clear coincides with the edge pulse, set wins
        enterB = 1'b1;
        step(2);
        store(32'hFFFF_FC78, 32'hFFFF_FFFF);
        load(32'hFFFF_FC78);
        check("flagB_set_wins", bus.MemorIO_Result, 32'h1);
        store(32'hFFFF_FC78, 32'h0);
        load(32'hFFFF_FC78);
        check("flagB_clear", bus.MemorIO_Result, 32'h0);
        enterB = 1'b0;

        // unmapped store leaves every register alone
        store(32'hFFFF_FCF0, 32'hFFFF_FFFF);
        check("unmapped_seg", 32'(IO_seg_out), 32'h0012_3456);
        check("unmapped_led", 32'(IO_led_out), 32'h00FF_00FF);
        check("unmapped_blink", 32'(IO_blink_out), 32'h1);
        load(32'hFFFF_FC74);
        check("unmapped_flagA", bus.MemorIO_Result, 32'h1);
        load(32'hFFFF_FC78);
        check("unmapped_flagB", bus.MemorIO_Result, 32'h0);

        // reset clears everything written above
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rst2_seg", 32'(IO_seg_out), 32'h0);
        check("rst2_blink", 32'(IO_blink_out), 32'h0);
        load(32'hFFFF_FC74);
        check("rst2_flagA", bus.MemorIO_Result, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
